// File: rtl/rr_arb_pkg.sv
// Purpose: shared types and helpers for the round-robin arbiter mux.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Contents: N_SRC source count, src_idx_t source index, next_idx() mod-4 increment.
package rr_arb_pkg;

   localparam int N_SRC = 4;

   typedef logic [1:0] src_idx_t;

   // Increment that wraps 3 -> 0; the 2-bit width does the modulo.
   function automatic src_idx_t next_idx(input src_idx_t idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/mux_4_1.sv
// Purpose: plain 4:1 data mux, W bits wide.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
// Ports: d0..d3 data sources, sel source index, y selected data.
module mux_4_1
   import rr_arb_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  src_idx_t     sel,
   output logic [W-1:0] y
);

   always_comb begin
      unique case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Purpose: 4-source round-robin arbiter + 4:1 mux into a single registered output slot.
// Latency: 1 cycle from source transfer to out_valid; sustains 1 word/cycle.
// Backpressure: in_ready is gated by out_valid/out_ready; a stalled slot grants nothing.
// Ports: clk, rst_n (async active-low); in_valid/in_data0..3/in_ready per source;
//        out_valid/out_data/out_src/out_ready towards the consumer.
module rr_arb_mux_4_1
   import rr_arb_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   in_valid,
   input  logic [W-1:0] in_data0,
   input  logic [W-1:0] in_data1,
   input  logic [W-1:0] in_data2,
   input  logic [W-1:0] in_data3,
   output logic [3:0]   in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output src_idx_t     out_src,
   input  logic         out_ready
);

   src_idx_t     last;       // most recently granted source (lowest priority next)
   src_idx_t     sel;        // current winner
   src_idx_t     scan;       // walking index for the priority scan
   logic         grant_vld;
   logic         can_accept;
   logic         xfer;
   logic [W-1:0] mux_y;

   // Output slot is free if empty or being drained this cycle.
   assign can_accept = !out_valid | out_ready;

   // Priority scan: last+1, last+2, last+3, last. First requester found wins.
   always_comb begin
      grant_vld = 1'b0;
      sel       = '0;
      scan      = last;
      for (int k = 0; k < N_SRC; k++) begin
         scan = next_idx(scan);
         if (!grant_vld && in_valid[scan]) begin
            grant_vld = 1'b1;
            sel       = scan;
         end
      end
   end

   assign xfer     = grant_vld & can_accept;
   assign in_ready = xfer ? (4'b0001 << sel) : 4'b0000;

   mux_4_1 #(.W(W)) u_mux (
      .d0  (in_data0),
      .d1  (in_data1),
      .d2  (in_data2),
      .d3  (in_data3),
      .sel (sel),
      .y   (mux_y)
   );

   // Pointer moves only on a transfer; a drain with no refill empties the
   // slot but leaves data/src as they were.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         last      <= 2'd3;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= mux_y;
         out_src   <= sel;
         last      <= sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
module tb_rr_arb_mux_4_1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [3:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0] in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic [1:0] out_src;
   logic       out_ready;

   typedef struct packed {
      logic [1:0] src;
      logic [3:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   rr_arb_mux_4_1 #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [3:0] d);
      exp_t e;
      e.src  = s;
      e.data = d;
      sb_q.push_back(e);
   endtask

   // Check the grant vector mid-cycle, then advance to just after the next edge.
   task automatic cyc(input logic [3:0] exp_rdy, input string nm);
      @(negedge clk);
      check(nm, {28'd0, in_ready}, {28'd0, exp_rdy});
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      check(nm, sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready_onehot0", {31'd0, ($countones(in_ready) <= 1)}, 32'd1);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_word", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("out_src", {30'd0, out_src}, {30'd0, e.src});
               check("out_data", {28'd0, out_data}, {28'd0, e.data});
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      in_data0  = 4'hA;
      in_data1  = 4'hB;
      in_data2  = 4'hC;
      in_data3  = 4'hD;
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {28'd0, out_data}, 32'd0);
      check("rst_out_src", {30'd0, out_src}, 32'd0);
      check("rst_in_ready", {28'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All four requesting: 0,1,2,3,0 one per cycle.
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      push(2'd0, 4'hA); push(2'd1, 4'hB); push(2'd2, 4'hC); push(2'd3, 4'hD); push(2'd0, 4'hA);
      cyc(4'b0001, "all_g0");
      cyc(4'b0010, "all_g1");
      cyc(4'b0100, "all_g2");
      cyc(4'b1000, "all_g3");
      cyc(4'b0001, "all_g0b");
      in_valid = 4'b0000;
      wait_drain("all_drain");

      // Sources 1 and 3 alternate (pointer now 0).
      in_valid = 4'b1010;
      push(2'd1, 4'hB); push(2'd3, 4'hD); push(2'd1, 4'hB); push(2'd3, 4'hD);
      cyc(4'b0010, "alt_g1");
      cyc(4'b1000, "alt_g3");
      cyc(4'b0010, "alt_g1b");
      cyc(4'b1000, "alt_g3b");
      in_valid = 4'b0000;
      wait_drain("alt_drain");

      // Back-pressure: first word (src 0) held for 3 cycles, then grant 1.
      in_valid = 4'b1111;
      push(2'd0, 4'hA); push(2'd1, 4'hB);
      cyc(4'b0001, "bp_g0");
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready", {28'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_data", {28'd0, out_data}, 32'hA);
         check("bp_out_src", {30'd0, out_src}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      cyc(4'b0010, "bp_after_g1");
      in_valid = 4'b0000;
      wait_drain("bp_drain");

      // Single requester 2, granted back-to-back.
      in_data2 = 4'h7;
      in_valid = 4'b0100;
      for (int k = 0; k < 4; k++) push(2'd2, 4'h7);
      for (int k = 0; k < 4; k++) cyc(4'b0100, "solo_g2");
      in_valid = 4'b0000;
      @(negedge clk);
      check("solo_last_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      check("solo_valid_fall", {31'd0, out_valid}, 32'd0);
      in_data2 = 4'hC;
      wait_drain("solo_drain");

      // Wrap: grant 3, then 0 and 3 from {0,3}.
      in_valid = 4'b1000;
      push(2'd3, 4'hD); push(2'd0, 4'hA); push(2'd3, 4'hD);
      cyc(4'b1000, "wrap_g3");
      in_valid = 4'b1001;
      cyc(4'b0001, "wrap_g0");
      cyc(4'b1000, "wrap_g3b");
      in_valid = 4'b0000;
      wait_drain("wrap_drain");

      // Reset mid-stream with a held word (src 2, pointer 2).
      out_ready = 1'b0;
      in_valid  = 4'b0100;
      cyc(4'b0100, "rstm_g2");
      in_valid = 4'b0000;
      check("rstm_held", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstm_out_valid", {31'd0, out_valid}, 32'd0);
      check("rstm_out_data", {28'd0, out_data}, 32'd0);
      check("rstm_out_src", {30'd0, out_src}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid  = 4'b0110;
      out_ready = 1'b1;
      push(2'd1, 4'hB);
      cyc(4'b0010, "rstm_first_g1");
      in_valid = 4'b0000;
      wait_drain("rstm_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux_4_1.md
Name: rr_arb_mux_4_1

Overview:
- 4-requester round-robin arbiter feeding a 4:1 data mux, followed by a single-entry registered output stage with valid/ready handshake.
- Sits upstream of the downstream consumer. Generates the 2-bit select that a 4:1 mux uses to pick one of four W-bit sources.
- Turns four independent valid/ready producers into one fair, back-pressured stream tagged with its source index.

Parameters:
- W, 4, data width of each source and of out_data.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  4  bit i: source i presents data
- in_data0  input  W  source 0 data
- in_data1  input  W  source 1 data
- in_data2  input  W  source 2 data
- in_data3  input  W  source 3 data
- in_ready  output  4  bit i: source i transfer accepted this cycle (one-hot or zero)
- out_valid  output  1  output register holds a word
- out_data  output  W  registered selected data
- out_src  output  2  index of the source that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (asserted immediately, not waiting for clk):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer last=3, so source 0 has first priority.
- can_accept = !out_valid | out_ready (combinational).
- Arbitration (combinational):
  - Scan order is last+1, last+2, last+3, last (mod 4).
  - The first index i with in_valid[i]=1 wins; sel=i.
  - No in_valid bit set gives no grant.
- in_ready[i] = (i is the winner) & can_accept.
  - At most one bit is set.
  - in_ready depends on in_valid and out_ready combinationally; it has no dependence on in_data.
- A transfer occurs when in_valid[i] & in_ready[i]. On the next clk edge:
  - out_data <= in_data[sel], out_src <= sel, out_valid <= 1, last <= sel.
- Drain without refill (out_valid & out_ready, no transfer): out_valid <= 0. out_data and out_src hold their old values.
- Stall (out_valid & !out_ready):
  - out_data, out_src and last hold.
  - in_ready=0.
  - Sources must hold their data.
- Throughput and latency:
  - Simultaneous drain and refill in the same cycle sustains 1 word/cycle.
  - Latency from source transfer to out_valid is 1 cycle.
- Pointer wrap: last=3 scans 0,1,2,3. last=0 scans 1,2,3,0.
- The pointer advances only on a transfer. A stalled or idle cycle never moves priority.
- Single active requester: it is granted every accepting cycle, including repeatedly after itself.
- Reset mid-operation: any held word is discarded (out_valid=0) and the pointer returns to 3. No transfer is in flight after reset release.
- No X propagation from unselected sources: only in_data[sel] is captured.

Decomposition:
- Shared package rr_arb_pkg:
  - localparam N_SRC=4.
  - typedef logic [1:0] src_idx_t.
  - Function next_idx(src_idx_t) for mod-4 increment.
- One natural sub-module: the existing 4:1 mux (mux_4_1). Instantiate it with sel=winner to form the captured data (W=4 default matches its width).
- The arbiter priority scan stays in this module.

Test Plan:
- Reset then all in_valid=4'b1111, data {d0..d3}={a,b,c,d}, out_ready=1 -> out_src sequence 0,1,2,3,0 with out_data a,b,c,d,a, one per cycle; in_ready one-hot each cycle.
- in_valid=4'b1010, out_ready=1 -> alternating grants 1,3,1,3; in_ready never sets bits 0 or 2.
- Back-pressure: out_ready=0 for 3 cycles after first word (src 0, data a) -> out_valid=1, out_data=a, out_src=0 held, in_ready=0, pointer unchanged. After release the next grant is 1.
- Only in_valid[2]=1, data 4'h7, continuous -> out_src=2, out_data=7 every cycle. Drop in_valid -> out_valid falls 1 cycle after the last accepted drain.
- Wrap: force last=3 via grant to src 3, then in_valid=4'b1001 -> next grant src 0, then src 3.
- Assert rst_n low mid-stream with out_valid=1 -> out_valid=0 immediately (asynchronous). After release, first grant goes to the lowest active index from 0.
